// File: rtl/hazard_scoreboard.sv
// Decode-stage scoreboard for long-latency register writes (loads, vector multiplies).
// Optional stall statistics counter enabled by defining SCOREBOARD_STATS_EN.
module hazard_scoreboard #(
    parameter int unsigned MEM_LAT  = 1,
    parameter int unsigned VMUL_LAT = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        id_valid,
    input  logic [3:0]  src2_reg,
    input  logic        src2_vf,
    input  logic        src2_en,
    input  logic [3:0]  src3_reg,
    input  logic        src3_vf,
    input  logic        src3_en,
    input  logic [3:0]  dst_reg,
    input  logic        dst_vf,
    input  logic        dst_we,
    input  logic [1:0]  lat_class,
    output logic        stall,
    output logic [4:0]  pending_cnt
`ifdef SCOREBOARD_STATS_EN
    ,
    output logic [15:0] stall_cycles
`endif
);

    localparam logic [2:0] MEM_L  = 3'(MEM_LAT);
    localparam logic [2:0] VMUL_L = 3'(VMUL_LAT);

    logic [2:0] cnt_q [32];
    logic [2:0] cnt_d [32];

    logic [4:0] src2_idx;
    logic [4:0] src3_idx;
    logic [4:0] dst_idx;
    logic       src2_hit;
    logic       src3_hit;
    logic       issue;
    logic       track;
    logic [2:0] lat_l;
    logic [2:0] dec;
    logic [4:0] pend;

    always_comb begin
        src2_idx = {src2_vf, src2_reg};
        src3_idx = {src3_vf, src3_reg};
        dst_idx  = {dst_vf, dst_reg};
        // Hazard check uses pre-issue state, so an instruction never stalls on its own write.
        src2_hit = src2_en & (src2_reg != 4'd0) & (cnt_q[src2_idx] != 3'd0);
        src3_hit = src3_en & (src3_reg != 4'd0) & (cnt_q[src3_idx] != 3'd0);
        stall    = id_valid & (src2_hit | src3_hit);
        issue    = id_valid & ~stall & ~flush;
        track    = issue & dst_we & (dst_reg != 4'd0) & (lat_class != 2'b00);
        lat_l    = (lat_class == 2'b01) ? MEM_L : VMUL_L;
    end

    always_comb begin
        dec = 3'd0;
        for (int i = 0; i < 32; i++) begin
            dec = (cnt_q[i] != 3'd0) ? (cnt_q[i] - 3'd1) : 3'd0;
            cnt_d[i] = dec;
            // WAW: keep the longer of the older write's remaining time and the new latency.
            if (track && (dst_idx == 5'(i))) begin
                cnt_d[i] = (dec > lat_l) ? dec : lat_l;
            end
            if (flush || (i == 0) || (i == 16)) begin
                cnt_d[i] = 3'd0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                cnt_q[i] <= 3'd0;
            end
        end else begin
            for (int i = 0; i < 32; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    always_comb begin
        pend = 5'd0;
        for (int i = 0; i < 32; i++) begin
            pend = pend + {4'd0, (cnt_q[i] != 3'd0)};
        end
        pending_cnt = pend;
    end

`ifdef SCOREBOARD_STATS_EN
    logic [15:0] stall_cycles_q;
    logic [15:0] stall_cycles_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall && (stall_cycles_q != 16'hFFFF)) begin
            stall_cycles_d = stall_cycles_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles_q <= 16'd0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard with MEM_LAT=1, VMUL_LAT=3.
module tb_hazard_scoreboard;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        id_valid;
    logic [3:0]  src2_reg;
    logic        src2_vf;
    logic        src2_en;
    logic [3:0]  src3_reg;
    logic        src3_vf;
    logic        src3_en;
    logic [3:0]  dst_reg;
    logic        dst_vf;
    logic        dst_we;
    logic [1:0]  lat_class;
    logic        stall;
    logic [4:0]  pending_cnt;
`ifdef SCOREBOARD_STATS_EN
    logic [15:0] stall_cycles;
`endif

    int checks;
    int failures;
    int exp_stalls;

    hazard_scoreboard #(.MEM_LAT(1), .VMUL_LAT(3)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .id_valid    (id_valid),
        .src2_reg    (src2_reg),
        .src2_vf     (src2_vf),
        .src2_en     (src2_en),
        .src3_reg    (src3_reg),
        .src3_vf     (src3_vf),
        .src3_en     (src3_en),
        .dst_reg     (dst_reg),
        .dst_vf      (dst_vf),
        .dst_we      (dst_we),
        .lat_class   (lat_class),
        .stall       (stall),
        .pending_cnt (pending_cnt)
`ifdef SCOREBOARD_STATS_EN
        ,
        .stall_cycles(stall_cycles)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_stall(input string tag, input logic exp);
        chk(tag, {15'd0, stall}, {15'd0, exp});
        if (exp) exp_stalls++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic dec(input logic v,
                       input logic [3:0] s2r, input logic s2v, input logic s2e,
                       input logic [3:0] s3r, input logic s3v, input logic s3e,
                       input logic [3:0] dr, input logic dv, input logic dwe,
                       input logic [1:0] lc);
        id_valid  = v;
        src2_reg  = s2r;
        src2_vf   = s2v;
        src2_en   = s2e;
        src3_reg  = s3r;
        src3_vf   = s3v;
        src3_en   = s3e;
        dst_reg   = dr;
        dst_vf    = dv;
        dst_we    = dwe;
        lat_class = lc;
        #1;
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        exp_stalls = 0;
        rst_n      = 1'b0;
        flush      = 1'b0;
        dec(1, 5,0,1, 0,0,0, 0,0,0, 2'b00);
        #1;
        chk_stall("rst_stall", 1'b0);
        chk("rst_pend", {11'd0, pending_cnt}, 16'd0);
`ifdef SCOREBOARD_STATS_EN
        chk("rst_stats", stall_cycles, 16'd0);
`endif
        #10;
        rst_n = 1'b1;

        // load to r3, dependent reader next cycle
        tick(); dec(1, 0,0,0, 0,0,0, 3,0,1, 2'b01);
        chk_stall("ld_issue", 1'b0);
        tick(); dec(1, 3,0,1, 0,0,0, 0,0,0, 2'b00);
        chk_stall("ld_dep_t1", 1'b1);
        chk("ld_pend_t1", {11'd0, pending_cnt}, 16'd1);
        tick();
        chk_stall("ld_dep_t2", 1'b0);
        chk("ld_pend_t2", {11'd0, pending_cnt}, 16'd0);

        // vector multiply to v7, reader on src3 stalls three cycles
        tick(); dec(1, 0,0,0, 0,0,0, 7,1,1, 2'b10);
        chk_stall("vm_issue", 1'b0);
        tick(); dec(1, 0,0,0, 7,1,1, 0,0,0, 2'b00);
        chk_stall("vm_t1", 1'b1);
        chk("vm_pend_t1", {11'd0, pending_cnt}, 16'd1);
        tick(); chk_stall("vm_t2", 1'b1);
        tick(); chk_stall("vm_t3", 1'b1);
        tick(); chk_stall("vm_t4", 1'b0);
        chk("vm_pend_t4", {11'd0, pending_cnt}, 16'd0);

        // multiply to v7 (class 11), scalar r7 reader must not stall
        tick(); dec(1, 0,0,0, 0,0,0, 7,1,1, 2'b11);
        tick(); dec(1, 7,0,1, 0,0,0, 0,0,0, 2'b00);
        chk_stall("vm_scalar_r7", 1'b0);
        chk("vm_scalar_pend", {11'd0, pending_cnt}, 16'd1);
        tick(); dec(1, 7,1,0, 7,1,0, 0,0,0, 2'b00);
        chk_stall("src_disabled", 1'b0);
        tick(); dec(0, 7,1,1, 0,0,0, 0,0,0, 2'b00);
        chk_stall("no_valid", 1'b0);

        // writes to r0 and single-cycle writes are never tracked
        tick(); dec(1, 0,0,0, 0,0,0, 0,0,1, 2'b01);
        chk("r0_pre_pend", {11'd0, pending_cnt}, 16'd0);
        tick(); dec(1, 0,0,1, 0,0,0, 4,0,1, 2'b00);
        chk_stall("r0_reader", 1'b0);
        chk("r0_pend", {11'd0, pending_cnt}, 16'd0);
        tick(); dec(1, 4,0,1, 0,0,1, 0,0,0, 2'b00);
        chk_stall("alu_reader", 1'b0);
        chk("alu_pend", {11'd0, pending_cnt}, 16'd0);

        // WAW: multiply v2 then load v2, reader stalls through t+3
        tick(); dec(1, 0,0,0, 0,0,0, 2,1,1, 2'b10);
        chk_stall("waw_mul", 1'b0);
        tick(); dec(1, 0,0,0, 0,0,0, 2,1,1, 2'b01);
        chk_stall("waw_ld", 1'b0);
        chk("waw_pend_t1", {11'd0, pending_cnt}, 16'd1);
        tick(); dec(1, 2,1,1, 0,0,0, 0,0,0, 2'b00);
        chk_stall("waw_t2", 1'b1);
        tick(); chk_stall("waw_t3", 1'b1);
        tick(); chk_stall("waw_t4", 1'b0);

        // source equals destination: no self-stall, next reader stalls
        tick(); dec(1, 6,0,1, 0,0,0, 6,0,1, 2'b01);
        chk_stall("self_dep", 1'b0);
        tick(); dec(1, 6,0,1, 0,0,0, 0,0,0, 2'b00);
        chk_stall("self_next", 1'b1);
        tick(); chk_stall("self_clear", 1'b0);

        // flush clears pending entries
        tick(); dec(1, 0,0,0, 0,0,0, 9,1,1, 2'b10);
        tick(); flush = 1'b1; dec(1, 9,1,1, 0,0,0, 0,0,0, 2'b00);
        chk_stall("fl_stall", 1'b1);
        chk("fl_pend_pre", {11'd0, pending_cnt}, 16'd1);
        tick(); flush = 1'b0; #1;
        chk_stall("fl_after", 1'b0);
        chk("fl_pend_post", {11'd0, pending_cnt}, 16'd0);

        // flush suppresses issue of a multiply
        tick(); flush = 1'b1; dec(1, 0,0,0, 0,0,0, 10,1,1, 2'b10);
        tick(); flush = 1'b0; dec(0, 0,0,0, 0,0,0, 0,0,0, 2'b00);
        chk("fl_sup_pend", {11'd0, pending_cnt}, 16'd0);
`ifdef SCOREBOARD_STATS_EN
        chk("stats_total", stall_cycles, 16'(exp_stalls));
`endif

        // asynchronous reset mid-stall
        tick(); dec(1, 0,0,0, 0,0,0, 11,1,1, 2'b10);
        tick(); dec(1, 11,1,1, 0,0,0, 0,0,0, 2'b00);
        chk("rst_mid_pre", {15'd0, stall}, 16'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_stall", {15'd0, stall}, 16'd0);
        chk("rst_mid_pend", {11'd0, pending_cnt}, 16'd0);
`ifdef SCOREBOARD_STATS_EN
        chk("rst_mid_stats", stall_cycles, 16'd0);
`endif
        #3 rst_n = 1'b1;
        tick();
        chk("rst_post_stall", {15'd0, stall}, 16'd0);
        chk("rst_post_pend", {11'd0, pending_cnt}, 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
